// File: rtl/regfile_burst_master_pkg.sv
// rtl/regfile_burst_master_pkg.sv - shared types and default widths for the register file burst master
//
// Package regfile_burst_pkg
//   ADDR_W_DEF / DATA_W_DEF / LEN_W_DEF : default address, data and burst length widths
//   burst_state_e                       : burst master state encoding
package regfile_burst_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE      = 3'd1,
    ST_READ_FETCH = 3'd2,
    ST_READ_HOLD  = 3'd3,
    ST_DONE       = 3'd4
  } burst_state_e;

endpackage

// File: rtl/regfile_burst_master_if.sv
// rtl/regfile_burst_master_if.sv - command, write, read and register file signals of the burst master
//
// Modport master : the burst master itself
//   in : cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, rf_read_data
//   out: cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
//        rf_enable_write, rf_write_addr, rf_write_data, rf_read_addr
// Modport slave  : upstream logic plus the register file, directions mirrored
interface regfile_burst_master_if #(
  parameter int ADDR_W = regfile_burst_pkg::ADDR_W_DEF,
  parameter int DATA_W = regfile_burst_pkg::DATA_W_DEF,
  parameter int LEN_W  = regfile_burst_pkg::LEN_W_DEF
);

  // command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  // write beat channel
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  // read beat channel
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  // status
  logic              busy;
  logic              done;

  // register file ports
  logic              rf_enable_write;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;
  logic [ADDR_W-1:0] rf_read_addr;
  logic [DATA_W-1:0] rf_read_data;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data,
    input  rd_ready,
    output busy, done,
    output rf_enable_write, rf_write_addr, rf_write_data, rf_read_addr,
    input  rf_read_data
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data,
    output rd_ready,
    input  busy, done,
    input  rf_enable_write, rf_write_addr, rf_write_data, rf_read_addr,
    output rf_read_data
  );

endinterface

// File: rtl/regfile_burst_master_addr_counter.sv
// rtl/regfile_burst_master_addr_counter.sv - burst address and remaining-beat counter
//
// Ports
//   clock, reset_n        : clock, asynchronous active-low reset
//   load                  : capture load_addr / load_len (start of burst)
//   step                  : one beat completed; address +1 (wrapping), remaining -1
//   load_addr, load_len   : start address and beats-minus-one
//   cur_addr              : address of the current beat
//   last                  : current beat is the final one of the burst
module burst_addr_counter #(
  parameter int ADDR_W = regfile_burst_pkg::ADDR_W_DEF,
  parameter int LEN_W  = regfile_burst_pkg::LEN_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              last
);

  logic [LEN_W-1:0] remaining;

  // Load wins over step; the master never asks for both in one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr  <= '0;
      remaining <= '0;
    end else if (load) begin
      cur_addr  <= load_addr;
      remaining <= load_len;
    end else if (step) begin
      cur_addr  <= cur_addr + ADDR_W'(1);
      remaining <= remaining - LEN_W'(1);
    end
  end

  assign last = (remaining == '0);

endmodule

// File: rtl/regfile_burst_master.sv
// rtl/regfile_burst_master.sv - burst initiator that streams data into and out of a register file
//
// Ports
//   clock, reset_n : clock, asynchronous active-low reset
//   bus            : regfile_burst_master_if.master - command, write beat and read beat
//                    channels, busy/done status, register file write and read ports
module regfile_burst_master
  import regfile_burst_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  regfile_burst_master_if.master bus
);

  burst_state_e      state_q, state_d;
  logic              cmd_fire, wr_fire, rd_fire;
  logic              last;
  logic [ADDR_W-1:0] cur_addr;

  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  assign cmd_fire = (state_q == ST_IDLE)      && bus.cmd_valid;
  assign wr_fire  = (state_q == ST_WRITE)     && bus.wr_valid;
  assign rd_fire  = (state_q == ST_READ_HOLD) && bus.rd_ready;

  burst_addr_counter #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_counter (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (cmd_fire),
    .step      (wr_fire | rd_fire),
    .load_addr (bus.cmd_addr),
    .load_len  (bus.cmd_len),
    .cur_addr  (cur_addr),
    .last      (last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (bus.cmd_valid) state_d = bus.cmd_write ? ST_WRITE : ST_READ_FETCH;
      ST_WRITE:      if (bus.wr_valid && last) state_d = ST_DONE;
      ST_READ_FETCH: state_d = ST_READ_HOLD;
      ST_READ_HOLD:  if (bus.rd_ready) state_d = last ? ST_DONE : ST_READ_FETCH;
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Write port: the beat is registered at its handshake edge, so the register
  // file commits it one cycle later; the final beat therefore lands at the
  // edge that leaves DONE, before any following read can fetch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= wr_fire;
      if (wr_fire) begin
        rf_waddr_q <= cur_addr;
        rf_wdata_q <= bus.wr_data;
      end
    end
  end

  // Read port: FETCH presents cur_addr to the combinational register file,
  // the data is captured on leaving FETCH and held through HOLD.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (state_q == ST_READ_FETCH) begin
      rd_valid_q <= 1'b1;
      rd_data_q  <= bus.rf_read_data;
    end else if (rd_fire) begin
      rd_valid_q <= 1'b0;
    end
  end

  assign bus.cmd_ready       = (state_q == ST_IDLE);
  assign bus.wr_ready        = (state_q == ST_WRITE);
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.done            = (state_q == ST_DONE);
  assign bus.rd_valid        = rd_valid_q;
  assign bus.rd_data         = rd_data_q;
  assign bus.rf_enable_write = rf_we_q;
  assign bus.rf_write_addr   = rf_waddr_q;
  assign bus.rf_write_data   = rf_wdata_q;
  // cur_addr is itself a flop, so the read address is registered.
  assign bus.rf_read_addr    = cur_addr;

endmodule
